// File: rtl/data_mem_responder.sv
// Data-memory responder: word RAM at BASE_ADDR with a fixed wait-state count
// before the single-cycle Ready pulse. Misaligned, out-of-range and read+write requests are faulted.
module data_mem_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h10010000,
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  input  logic        MemRead,
  output logic [31:0] ReadData,
  output logic        Ready,
  output logic        Fault,
  output logic        Busy
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [32:0] LP_LIMIT = 33'(BASE_ADDR) + 33'(DEPTH) * 33'd4;
  localparam logic [3:0]  LP_CNT0  = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t        r_state, w_next;
  logic [3:0]    r_cnt;
  logic          r_fault, r_we;
  logic [AW-1:0] r_idx;
  logic [31:0]   r_wdata, r_rdata;
  logic [31:0]   r_mem [DEPTH];

  logic          w_req, w_fault, w_enter;
  logic [31:0]   w_off;
  logic [AW-1:0] w_idx;
  logic          w_acc_fault, w_acc_we;
  logic [AW-1:0] w_acc_idx;
  logic [31:0]   w_acc_wdata;

  // Upper bound compared at 33 bits so BASE_ADDR + 4*DEPTH cannot wrap
  assign w_req   = MemRead | MemWrite;
  assign w_off   = Addr - BASE_ADDR;
  assign w_idx   = AW'(w_off >> 2);
  assign w_fault = (Addr[1:0] != 2'b00) | (Addr < BASE_ADDR) |
                   ({1'b0, Addr} >= LP_LIMIT) | (MemRead & MemWrite);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && w_req) r_cnt <= LP_CNT0;
      else if (r_state == S_WAIT && r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_req) w_next = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
      S_WAIT:  if (r_cnt == 4'd0) w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    Ready = (r_state == S_RESP);
    Fault = (r_state == S_RESP) & r_fault;
    Busy  = (r_state != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fault <= 1'b0;
      r_we    <= 1'b0;
      r_idx   <= '0;
      r_wdata <= '0;
    end else if (r_state == S_IDLE && w_req) begin
      r_fault <= w_fault;
      r_we    <= MemWrite;
      r_idx   <= w_idx;
      r_wdata <= WriteData;
    end
  end

  // With zero wait states the access happens on the accept edge, so use live inputs
  assign w_enter     = (w_next == S_RESP) && (r_state != S_RESP);
  assign w_acc_fault = (r_state == S_IDLE) ? w_fault   : r_fault;
  assign w_acc_we    = (r_state == S_IDLE) ? MemWrite  : r_we;
  assign w_acc_idx   = (r_state == S_IDLE) ? w_idx     : r_idx;
  assign w_acc_wdata = (r_state == S_IDLE) ? WriteData : r_wdata;

  always_ff @(posedge clk) begin
    if (!rst && w_enter && w_acc_we && !w_acc_fault)
      r_mem[w_acc_idx] <= w_acc_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (w_enter) begin
      if (w_acc_fault)   r_rdata <= '0;
      else if (!w_acc_we) r_rdata <= r_mem[w_acc_idx];
    end
  end

  assign ReadData = r_rdata;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: one instance with two wait states, one with none,
// driven from a shared vector table with a response scoreboard.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  logic        mw [2], mr [2], rdy [2], flt [2], bsy [2];

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.BASE_ADDR(32'h10010000), .DEPTH(1024), .WAIT_STATES(2)) u_ws2 (
    .clk(clk), .rst(rst), .Addr(addr[0]), .WriteData(wdata[0]), .MemWrite(mw[0]),
    .MemRead(mr[0]), .ReadData(rdata[0]), .Ready(rdy[0]), .Fault(flt[0]), .Busy(bsy[0]));

  data_mem_responder #(.BASE_ADDR(32'h10010000), .DEPTH(1024), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .rst(rst), .Addr(addr[1]), .WriteData(wdata[1]), .MemWrite(mw[1]),
    .MemRead(mr[1]), .ReadData(rdata[1]), .Ready(rdy[1]), .Fault(flt[1]), .Busy(bsy[1]));

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        re;
    logic        exp_fault;
    logic [31:0] exp_rd;
    logic        chk_rd;
  } vec_t;

  typedef struct {
    logic        fault;
    logic [31:0] rd;
    logic        chk_rd;
    int          lat;
  } exp_t;

  exp_t sbq [$];
  vec_t tbl [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic [31:0] a, input logic [31:0] d, input logic we,
                              input logic re, input logic f, input logic [31:0] rd,
                              input logic chk);
    vec_t v;
    v.addr = a; v.wdata = d; v.we = we; v.re = re;
    v.exp_fault = f; v.exp_rd = rd; v.chk_rd = chk;
    return v;
  endfunction

  // Issue one request, hold it until Ready, then compare against the scoreboard entry
  task automatic do_req(input int sel, input vec_t v, input string tag);
    exp_t e;
    int   k;
    bit   got;
    e.fault = v.exp_fault; e.rd = v.exp_rd; e.chk_rd = v.chk_rd;
    e.lat = (sel == 0) ? 3 : 1;
    sbq.push_back(e);
    @(negedge clk);
    addr[sel] = v.addr; wdata[sel] = v.wdata; mw[sel] = v.we; mr[sel] = v.re;
    @(posedge clk);
    k = 0; got = 0;
    while (!got && k < 40) begin
      @(negedge clk);
      k++;
      if (k == 1) check({tag, " busy"}, 32'(bsy[sel]), 32'd1);
      if (rdy[sel]) got = 1;
    end
    mw[sel] = 1'b0; mr[sel] = 1'b0;
    e = sbq.pop_front();
    if (!got) begin
      check({tag, " ready timeout"}, 32'd0, 32'd1);
    end else begin
      check({tag, " latency"}, 32'(k), 32'(e.lat));
      check({tag, " fault"}, 32'(flt[sel]), 32'(e.fault));
      if (e.chk_rd) check({tag, " rdata"}, rdata[sel], e.rd);
    end
  endtask

  initial begin
    bit saw;
    int k;
    for (int i = 0; i < 2; i++) begin
      addr[i] = '0; wdata[i] = '0; mw[i] = 1'b0; mr[i] = 1'b0;
    end

    tbl[0]  = mk(32'h10010008, 32'hDEADBEEF, 1, 0, 0, 32'h0,        0);
    tbl[1]  = mk(32'h10010008, 32'h0,        0, 1, 0, 32'hDEADBEEF, 1);
    tbl[2]  = mk(32'h10010002, 32'h0,        0, 1, 1, 32'h0,        1);
    tbl[3]  = mk(32'h1000FFFC, 32'h0,        0, 1, 1, 32'h0,        1);
    tbl[4]  = mk(32'h10011000, 32'h0,        0, 1, 1, 32'h0,        1);
    tbl[5]  = mk(32'hFFFFFFFC, 32'h0,        0, 1, 1, 32'h0,        1);
    tbl[6]  = mk(32'h10010000, 32'hA5A50000, 1, 0, 0, 32'h0,        0);
    tbl[7]  = mk(32'h10010FFC, 32'hCAFEF00D, 1, 0, 0, 32'h0,        0);
    tbl[8]  = mk(32'h10010FFC, 32'h0,        0, 1, 0, 32'hCAFEF00D, 1);
    tbl[9]  = mk(32'h10010000, 32'h0,        0, 1, 0, 32'hA5A50000, 1);
    tbl[10] = mk(32'h10010010, 32'h00000055, 1, 0, 0, 32'h0,        0);
    tbl[11] = mk(32'h10010010, 32'hFFFFFFFF, 1, 1, 1, 32'h0,        1);
    tbl[12] = mk(32'h10010010, 32'h0,        0, 1, 0, 32'h00000055, 1);

    // Reset held for two edges, then idle with no request
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst%0d flags", i), {29'd0, rdy[i], flt[i], bsy[i]}, 32'd0);
      check($sformatf("rst%0d rdata", i), rdata[i], 32'd0);
    end
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        check($sformatf("idle%0d flags", i), {29'd0, rdy[i], flt[i], bsy[i]}, 32'd0);
        check($sformatf("idle%0d rdata", i), rdata[i], 32'd0);
      end
    end

    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 13; i++)
        do_req(s, tbl[i], $sformatf("dut%0d vec%0d", s, i));

    // Request held through RESP is re-accepted once back in IDLE
    @(negedge clk);
    addr[0] = 32'h10010000; mr[0] = 1'b1;
    k = 0;
    while (!rdy[0] && k < 40) begin @(negedge clk); k++; end
    check("held first rdata", rdata[0], 32'hA5A50000);
    @(negedge clk);
    check("held idle busy", 32'(bsy[0]), 32'd0);
    @(negedge clk);
    check("held reaccept busy", 32'(bsy[0]), 32'd1);
    mr[0] = 1'b0;
    k = 0;
    while (!rdy[0] && k < 40) begin @(negedge clk); k++; end
    check("held second ready", 32'(rdy[0]), 32'd1);
    check("held second rdata", rdata[0], 32'hA5A50000);

    // Reset during WAIT abandons the store
    @(negedge clk);
    addr[0] = 32'h10010008; wdata[0] = 32'h00001234; mw[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort busy before rst", 32'(bsy[0]), 32'd1);
    rst = 1'b1; mw[0] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    saw = 0;
    repeat (6) begin
      @(negedge clk);
      if (rdy[0]) saw = 1;
    end
    check("abort no ready", 32'(saw), 32'd0);
    check("abort busy after", 32'(bsy[0]), 32'd0);
    do_req(0, mk(32'h10010008, 32'h0, 0, 1, 0, 32'hDEADBEEF, 1), "abort reload");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
